// File: rtl/result_collector.sv
// Gathers the nine elements of a 3x3 result matrix in any order, then streams
// them out in row-major order over a valid/ready handshake.
module result_collector #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          res_valid,
  input  logic [3:0]    res_idx,
  input  logic [DW-1:0] res_data,
  output logic          res_ready,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [3:0]    m_idx,
  output logic          m_last,
  output logic          busy,
  output logic          err
);

  localparam logic COLLECT = 1'b0;
  localparam logic DRAIN   = 1'b1;

  logic          state;
  logic [DW-1:0] mem [0:8];
  logic [8:0]    mask;
  logic [3:0]    ptr;

  logic [1:0] wr_row;
  logic [1:0] wr_col;
  logic [3:0] wr_entry;
  logic       bad_idx;
  logic       in_hs;
  logic       out_hs;

  always_comb begin
    wr_row   = res_idx[1:0];
    wr_col   = res_idx[3:2];
    bad_idx  = (wr_row == 2'd3) || (wr_col == 2'd3);
    // row*3 + col, formed as row*2 + row + col
    wr_entry = {1'b0, wr_row, 1'b0} + {2'b00, wr_row} + {2'b00, wr_col};
    in_hs    = res_valid & res_ready;
    out_hs   = m_valid & m_ready;
  end

  always_comb begin
    res_ready = (state == COLLECT);
    m_valid   = (state == DRAIN);
    busy      = (state == DRAIN);
    m_last    = (state == DRAIN) && (ptr == 4'd8);
    m_data    = (state == DRAIN) ? mem[ptr] : '0;
    m_idx     = '0;
    if (state == DRAIN) begin
      case (ptr)
        4'd0:    m_idx = 4'h0;
        4'd1:    m_idx = 4'h4;
        4'd2:    m_idx = 4'h8;
        4'd3:    m_idx = 4'h1;
        4'd4:    m_idx = 4'h5;
        4'd5:    m_idx = 4'h9;
        4'd6:    m_idx = 4'h2;
        4'd7:    m_idx = 4'h6;
        4'd8:    m_idx = 4'hA;
        default: m_idx = 4'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= COLLECT;
      mask  <= '0;
      ptr   <= '0;
      err   <= 1'b0;
      mem   <= '{default: '0};
    end else if (clear) begin
      state <= COLLECT;
      mask  <= '0;
      ptr   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          // A full mask seen here gives the one-cycle entry latency into DRAIN
          if (mask == '1) begin
            state <= DRAIN;
            ptr   <= '0;
          end
          if (in_hs) begin
            if (bad_idx) begin
              err <= 1'b1;
            end else begin
              mem[wr_entry]  <= res_data;
              mask[wr_entry] <= 1'b1;
              if (mask[wr_entry]) err <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_hs) begin
            if (ptr == 4'd8) begin
              mask  <= '0;
              ptr   <= '0;
              state <= COLLECT;
            end else begin
              ptr <= ptr + 4'd1;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_result_collector.sv
// Directed scenarios with random data, checked against a matrix-level model.
module tb_result_collector;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset, clear, res_valid, m_ready;
  logic [3:0]    res_idx;
  logic [DW-1:0] res_data;
  logic          res_ready, m_valid, m_last, busy, err;
  logic [DW-1:0] m_data;
  logic [3:0]    m_idx;

  result_collector #(.DW(DW)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data),
    .res_ready(res_ready), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_idx(m_idx), .m_last(m_last),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  logic [DW-1:0] mdl [9];
  bit            filled [9];
  bit            mdl_err;

  function automatic logic [3:0] idx_of(int k);
    return 4'(((k % 3) << 2) | (k / 3));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(bit full_reset);
    for (int i = 0; i < 9; i++) begin
      filled[i] = 1'b0;
      if (full_reset) mdl[i] = '0;
    end
    mdl_err = 1'b0;
  endtask

  task automatic chk_idle(string tag);
    chk({tag, "_m_valid"}, m_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_res_ready"}, res_ready, 1'b1);
    chk({tag, "_m_last"}, m_last, 1'b0);
  endtask

  task automatic chk_reset_outputs(string tag);
    chk_idle(tag);
    chk({tag, "_m_data"}, m_data, '0);
    chk({tag, "_m_idx"}, m_idx, 4'h0);
    chk({tag, "_err"}, err, 1'b0);
  endtask

  task automatic wr(logic [3:0] idx, logic [DW-1:0] d);
    int r, c;
    chk("wr_res_ready", res_ready, 1'b1);
    res_valid = 1'b1; res_idx = idx; res_data = d;
    tick();
    res_valid = 1'b0;
    r = int'(idx[1:0]);
    c = int'(idx[3:2]);
    if (r == 3 || c == 3) mdl_err = 1'b1;
    else begin
      if (filled[r*3 + c]) mdl_err = 1'b1;
      filled[r*3 + c] = 1'b1;
      mdl[r*3 + c] = d;
    end
    chk("wr_err", err, mdl_err);
  endtask

  // After the ninth write the collector stays idle for exactly one cycle
  task automatic enter_drain();
    chk("latency_m_valid", m_valid, 1'b0);
    chk("latency_busy", busy, 1'b0);
    tick();
  endtask

  task automatic fill_random();
    int ord [9];
    int j, t;
    for (int i = 0; i < 9; i++) ord[i] = i;
    for (int i = 8; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = ord[i]; ord[i] = ord[j]; ord[j] = t;
    end
    for (int i = 0; i < 9; i++) wr(idx_of(ord[i]), DW'($urandom));
    enter_drain();
  endtask

  task automatic drain(int stall_at, bit inject);
    for (int k = 0; k < 9; k++) begin
      chk("drain_m_valid", m_valid, 1'b1);
      chk("drain_m_data", m_data, mdl[k]);
      chk("drain_m_idx", m_idx, idx_of(k));
      chk("drain_m_last", m_last, k == 8);
      chk("drain_busy", busy, 1'b1);
      chk("drain_res_ready", res_ready, 1'b0);
      if (k == stall_at) begin
        m_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          chk("hold_m_valid", m_valid, 1'b1);
          chk("hold_m_data", m_data, mdl[k]);
          chk("hold_m_idx", m_idx, idx_of(k));
          chk("hold_m_last", m_last, k == 8);
        end
        m_ready = 1'b1;
      end
      if (inject && k == 1) begin
        res_valid = 1'b1; res_idx = 4'h0; res_data = DW'($urandom);
      end
      tick();
      res_valid = 1'b0;
      chk("drain_err", err, mdl_err);
    end
    for (int i = 0; i < 9; i++) filled[i] = 1'b0;
    chk_idle("after_drain");
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; res_valid = 1'b0; m_ready = 1'b1;
    res_idx = '0; res_data = '0;
    model_clear(1'b1);
    tick(); tick();
    chk_reset_outputs("in_reset");
    reset = 1'b0;
    tick();
    chk_reset_outputs("post_reset");

    // In-order fill with 0x100+k
    for (int k = 0; k < 9; k++) wr(idx_of(k), DW'(32'h100 + k));
    enter_drain();
    drain(-1, 1'b0);

    // Column-major fill, row-major drain
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++) wr(idx_of(r*3 + c), DW'($urandom));
    enter_drain();
    drain(-1, 1'b0);
    chk("colmajor_err", err, 1'b0);

    // Backpressure at pointer 4, with a write attempted during DRAIN
    fill_random();
    drain(4, 1'b1);

    // Error cases: out-of-range index, then duplicate write
    wr(4'h3, DW'($urandom));
    chk("bad_idx_err", err, 1'b1);
    wr(4'h0, DW'($urandom));
    wr(4'h0, DW'(32'hDEAD));
    for (int k = 1; k < 9; k++) wr(idx_of(k), DW'($urandom));
    enter_drain();
    drain(-1, 1'b0);
    chk("err_sticky", err, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_clear(1'b0);
    chk("clear_err", err, 1'b0);

    // Clear after 5 writes, with a write colliding with the clear
    for (int k = 0; k < 5; k++) wr(idx_of(k), DW'($urandom));
    clear = 1'b1; res_valid = 1'b1; res_idx = idx_of(5); res_data = DW'($urandom);
    tick();
    clear = 1'b0; res_valid = 1'b0;
    model_clear(1'b0);
    chk_idle("after_clear");
    chk("after_clear_err", err, 1'b0);
    fill_random();
    drain(-1, 1'b0);
    chk("post_clear_err", err, 1'b0);

    // Reset in the middle of a drain at pointer 3
    fill_random();
    for (int k = 0; k < 3; k++) begin
      chk("pre_reset_m_data", m_data, mdl[k]);
      tick();
    end
    chk("pre_reset_m_idx", m_idx, idx_of(3));
    reset = 1'b1;
    tick();
    chk_reset_outputs("mid_drain_reset");
    reset = 1'b0;
    model_clear(1'b1);
    tick();
    chk_reset_outputs("after_mid_reset");
    fill_random();
    drain(-1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
